// File: rtl/scr1_dmem_router_if.sv
// Shared memory-request types and the request/response bundle that runs
// between the pipeline, the router and each target.
package scr1_dmem_router_pkg;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

interface scr1_dmem_router_if;
  import scr1_dmem_router_pkg::*;

  logic                        req;
  type_scr1_mem_cmd_e          cmd;
  type_scr1_mem_width_e        width;
  logic [SCR1_DMEM_AWIDTH-1:0] addr;
  logic [SCR1_DMEM_DWIDTH-1:0] wdata;
  logic                        req_ack;
  logic [SCR1_DMEM_DWIDTH-1:0] rdata;
  type_scr1_mem_resp_e         resp;

  modport master (
    output req, cmd, width, addr, wdata,
    input  req_ack, rdata, resp
  );

  modport slave (
    input  req, cmd, width, addr, wdata,
    output req_ack, rdata, resp
  );
endinterface

// File: rtl/scr1_dmem_router.sv
// Routes pipeline data requests to TCM (port1), timer (port2) or external bus
// (port0) and returns the selected target's response; one transaction in flight.
module scr1_dmem_router
  import scr1_dmem_router_pkg::*;
#(
  parameter logic [31:0] PORT1_ADDR_MASK    = 32'hFFFF_0000,
  parameter logic [31:0] PORT1_ADDR_PATTERN = 32'h0048_0000,
  parameter logic [31:0] PORT2_ADDR_MASK    = 32'hFFFF_FFE0,
  parameter logic [31:0] PORT2_ADDR_PATTERN = 32'h0049_0000
) (
  input  logic                clk,
  input  logic                rst,
  scr1_dmem_router_if.slave   dmem,
  scr1_dmem_router_if.master  port0,
  scr1_dmem_router_if.master  port1,
  scr1_dmem_router_if.master  port2
);

  typedef enum logic {
    FSM_ADDR = 1'b0,
    FSM_DATA = 1'b1
  } fsm_e;

  fsm_e                        fsm_q, fsm_d;
  logic [1:0]                  port_sel_q, port_sel_d;
  logic                        port1_hit, port2_hit;
  logic [1:0]                  dec_sel;
  logic                        dec_ack;
  type_scr1_mem_resp_e         sel_resp;
  logic [SCR1_DMEM_DWIDTH-1:0] sel_rdata;
  logic                        issue;
  type_scr1_mem_resp_e         resp_out;
  logic [SCR1_DMEM_DWIDTH-1:0] rdata_out;

  assign port1_hit = (dmem.addr & PORT1_ADDR_MASK) == PORT1_ADDR_PATTERN;
  assign port2_hit = (dmem.addr & PORT2_ADDR_MASK) == PORT2_ADDR_PATTERN;

  always_comb begin
    dec_sel = 2'd0;
    if (port1_hit) begin
      dec_sel = 2'd1;
    end else if (port2_hit) begin
      dec_sel = 2'd2;
    end
  end

  always_comb begin
    case (dec_sel)
      2'd1:    dec_ack = port1.req_ack;
      2'd2:    dec_ack = port2.req_ack;
      default: dec_ack = port0.req_ack;
    endcase
  end

  // Only the target that owns the outstanding transaction is listened to.
  always_comb begin
    case (port_sel_q)
      2'd1: begin
        sel_resp  = port1.resp;
        sel_rdata = port1.rdata;
      end
      2'd2: begin
        sel_resp  = port2.resp;
        sel_rdata = port2.rdata;
      end
      default: begin
        sel_resp  = port0.resp;
        sel_rdata = port0.rdata;
      end
    endcase
  end

  always_comb begin
    fsm_d      = fsm_q;
    port_sel_d = port_sel_q;
    issue      = 1'b0;
    resp_out   = SCR1_MEM_RESP_NOTRDY;
    rdata_out  = '0;
    if (!rst) begin
      if (fsm_q == FSM_ADDR) begin
        issue = 1'b1;
      end else begin
        resp_out = sel_resp;
        case (sel_resp)
          SCR1_MEM_RESP_RDY_OK: begin
            rdata_out = sel_rdata;
            issue     = 1'b1;
            fsm_d     = FSM_ADDR;
          end
          SCR1_MEM_RESP_RDY_ER: fsm_d = FSM_ADDR;
          default: ;
        endcase
      end
      // A completing OK response lets the next request go out in the same cycle.
      if (issue && dmem.req && dec_ack) begin
        fsm_d      = FSM_DATA;
        port_sel_d = dec_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= FSM_ADDR;
      port_sel_q <= 2'd0;
    end else begin
      fsm_q      <= fsm_d;
      port_sel_q <= port_sel_d;
    end
  end

  assign dmem.req_ack = issue & dec_ack;
  assign dmem.resp    = resp_out;
  assign dmem.rdata   = rdata_out;

  assign port0.req   = issue & dmem.req & (dec_sel == 2'd0);
  assign port1.req   = issue & dmem.req & (dec_sel == 2'd1);
  assign port2.req   = issue & dmem.req & (dec_sel == 2'd2);

  assign port0.cmd   = dmem.cmd;
  assign port0.width = dmem.width;
  assign port0.addr  = dmem.addr;
  assign port0.wdata = dmem.wdata;
  assign port1.cmd   = dmem.cmd;
  assign port1.width = dmem.width;
  assign port1.addr  = dmem.addr;
  assign port1.wdata = dmem.wdata;
  assign port2.cmd   = dmem.cmd;
  assign port2.width = dmem.width;
  assign port2.addr  = dmem.addr;
  assign port2.wdata = dmem.wdata;

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Randomized and directed bench for scr1_dmem_router against a
// transaction-level model of the outstanding request.
module tb_scr1_dmem_router;
  import scr1_dmem_router_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scr1_dmem_router_if dmem_if ();
  scr1_dmem_router_if p0_if ();
  scr1_dmem_router_if p1_if ();
  scr1_dmem_router_if p2_if ();

  scr1_dmem_router dut (
    .clk  (clk),
    .rst  (rst),
    .dmem (dmem_if),
    .port0(p0_if),
    .port1(p1_if),
    .port2(p2_if)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int pending = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int decode(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h0048_0000) return 1;
    if ((a & 32'hFFFF_FFE0) == 32'h0049_0000) return 2;
    return 0;
  endfunction

  function automatic logic port_ack(input int n);
    if (n == 1) return p1_if.req_ack;
    if (n == 2) return p2_if.req_ack;
    return p0_if.req_ack;
  endfunction

  function automatic logic [1:0] port_resp(input int n);
    if (n == 1) return p1_if.resp;
    if (n == 2) return p2_if.resp;
    return p0_if.resp;
  endfunction

  function automatic logic [31:0] port_rdata(input int n);
    if (n == 1) return p1_if.rdata;
    if (n == 2) return p2_if.rdata;
    return p0_if.rdata;
  endfunction

  // Model: the request in flight is just the index of the target that took it.
  always @(negedge clk) begin : cmp_blk
    int          tgt;
    logic [2:0]  ereq;
    logic        eack;
    logic [1:0]  eresp;
    logic [31:0] erd;
    bit          can;
    tgt   = decode(dmem_if.addr);
    can   = 1'b0;
    ereq  = 3'b000;
    eack  = 1'b0;
    eresp = 2'b00;
    erd   = 32'h0;
    if (!rst) begin
      eresp = (pending < 0) ? 2'b00 : port_resp(pending);
      erd   = (eresp == 2'b01) ? port_rdata(pending) : 32'h0;
      can   = (pending < 0) || (eresp == 2'b01);
      ereq  = (can && dmem_if.req) ? (3'b001 << tgt) : 3'b000;
      eack  = can && port_ack(tgt);
    end
    chk("port_req", {p2_if.req, p1_if.req, p0_if.req}, ereq);
    chk("req_ack", dmem_if.req_ack, eack);
    chk("resp", dmem_if.resp, eresp);
    chk("rdata", dmem_if.rdata, erd);
    chk("fields", {p0_if.addr, p1_if.wdata, p2_if.cmd, p2_if.width},
        {dmem_if.addr, dmem_if.wdata, dmem_if.cmd, dmem_if.width});
    if (rst) begin
      pending = -1;
    end else begin
      if (pending >= 0 && eresp != 2'b00) pending = -1;
      if (can && dmem_if.req && port_ack(tgt)) pending = tgt;
    end
  end

  task automatic step(input bit r, input bit rq, input logic [31:0] a, input logic [2:0] acks,
                      input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] r2,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    @(posedge clk);
    #1;
    rst             = r;
    dmem_if.req     = rq;
    dmem_if.addr    = a;
    dmem_if.cmd     = type_scr1_mem_cmd_e'($urandom_range(0, 1));
    dmem_if.width   = type_scr1_mem_width_e'($urandom_range(0, 2));
    dmem_if.wdata   = $urandom;
    p0_if.req_ack   = acks[0];
    p1_if.req_ack   = acks[1];
    p2_if.req_ack   = acks[2];
    p0_if.resp      = type_scr1_mem_resp_e'(r0);
    p1_if.resp      = type_scr1_mem_resp_e'(r1);
    p2_if.resp      = type_scr1_mem_resp_e'(r2);
    p0_if.rdata     = d0;
    p1_if.rdata     = d1;
    p2_if.rdata     = d2;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [1:0] rand_resp();
    int v;
    v = $urandom_range(0, 9);
    if (v < 5) return 2'b00;
    if (v < 9) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 32'h0048_0000 | ($urandom & 32'h0000_FFFC);
      1: return 32'h0049_0000 | ($urandom & 32'h0000_001C);
      2: return 32'h0049_0020;
      3: return 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
      4: return 32'h0047_FFFC;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst           = 1'b1;
    dmem_if.req   = 1'b1;
    dmem_if.addr  = 32'h0048_0010;
    dmem_if.cmd   = SCR1_MEM_CMD_RD;
    dmem_if.width = SCR1_MEM_WIDTH_WORD;
    dmem_if.wdata = 32'h0;
    p0_if.req_ack = 1'b1;  p1_if.req_ack = 1'b1;  p2_if.req_ack = 1'b1;
    p0_if.resp = SCR1_MEM_RESP_NOTRDY;
    p1_if.resp = SCR1_MEM_RESP_NOTRDY;
    p2_if.resp = SCR1_MEM_RESP_NOTRDY;
    p0_if.rdata = 32'h0;  p1_if.rdata = 32'h0;  p2_if.rdata = 32'h0;

    // Reset held two cycles with a request pending.
    step(1, 1, 32'h0048_0010, 3'b111, 2'b01, 2'b01, 2'b01, 32'h1, 32'h2, 32'h3);
    step(1, 1, 32'h0048_0010, 3'b111, 2'b01, 2'b01, 2'b01, 32'h1, 32'h2, 32'h3);
    chk("rst_req", {p2_if.req, p1_if.req, p0_if.req}, 3'b000);
    chk("rst_resp", dmem_if.resp, 2'b00);
    chk("rst_ack", dmem_if.req_ack, 1'b0);

    // TCM read.
    step(0, 1, 32'h0048_0010, 3'b010, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    chk("tcm_req", {p2_if.req, p1_if.req, p0_if.req}, 3'b010);
    chk("tcm_ack", dmem_if.req_ack, 1'b1);
    step(0, 0, 32'h0048_0010, 3'b000, 2'b00, 2'b01, 2'b00, 32'h0, 32'hDEAD_BEEF, 32'h0);
    chk("tcm_resp", dmem_if.resp, 2'b01);
    chk("tcm_rdata", dmem_if.rdata, 32'hDEAD_BEEF);

    // Timer read.
    step(0, 1, 32'h0049_0008, 3'b100, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    chk("tmr_req", {p2_if.req, p1_if.req, p0_if.req}, 3'b100);
    step(0, 0, 32'h0049_0008, 3'b000, 2'b01, 2'b01, 2'b01, 32'h1, 32'h2, 32'h1234_5678);
    chk("tmr_rdata", dmem_if.rdata, 32'h1234_5678);

    // External read with three wait cycles on the ack.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h8000_0000, 3'b000, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
      chk("ext_wait_req", {p2_if.req, p1_if.req, p0_if.req}, 3'b001);
      chk("ext_wait_ack", dmem_if.req_ack, 1'b0);
    end
    step(0, 1, 32'h8000_0000, 3'b001, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    chk("ext_ack", dmem_if.req_ack, 1'b1);
    step(0, 0, 32'h8000_0000, 3'b000, 2'b01, 2'b01, 2'b00, 32'hCAFE_0000, 32'h1111_1111, 32'h0);
    chk("ext_rdata", dmem_if.rdata, 32'hCAFE_0000);

    // Back-to-back: TCM completes while an external request is accepted.
    step(0, 1, 32'h0048_0010, 3'b010, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    step(0, 1, 32'h8000_0004, 3'b001, 2'b00, 2'b01, 2'b00, 32'h0, 32'hA5A5_A5A5, 32'h0);
    chk("b2b_ack", dmem_if.req_ack, 1'b1);
    chk("b2b_req", {p2_if.req, p1_if.req, p0_if.req}, 3'b001);
    chk("b2b_rdata0", dmem_if.rdata, 32'hA5A5_A5A5);
    step(0, 0, 32'h8000_0004, 3'b000, 2'b01, 2'b01, 2'b00, 32'h0BAD_F00D, 32'h7777_7777, 32'h0);
    chk("b2b_rdata1", dmem_if.rdata, 32'h0BAD_F00D);

    // Error response blocks issue for one cycle.
    step(0, 1, 32'h8000_0008, 3'b001, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    step(0, 1, 32'h8000_0000, 3'b001, 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    chk("err_resp", dmem_if.resp, 2'b10);
    chk("err_ack", dmem_if.req_ack, 1'b0);
    chk("err_req", {p2_if.req, p1_if.req, p0_if.req}, 3'b000);
    chk("err_rdata", dmem_if.rdata, 32'h0);
    step(0, 1, 32'h8000_0000, 3'b001, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    chk("err_next_ack", dmem_if.req_ack, 1'b1);
    step(0, 0, 32'h8000_0000, 3'b000, 2'b01, 2'b00, 2'b00, 32'h55, 32'h0, 32'h0);
    chk("err_next_rdata", dmem_if.rdata, 32'h55);

    // Reset while waiting on the timer.
    step(0, 1, 32'h0049_0004, 3'b100, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    step(1, 0, 32'h0049_0004, 3'b000, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0049_0004, 3'b000, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0, 32'h99);
    chk("rst_mid_resp", dmem_if.resp, 2'b00);
    chk("rst_mid_rdata", dmem_if.rdata, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rand_addr(),
           3'($urandom), rand_resp(), rand_resp(), rand_resp(),
           $urandom, $urandom, $urandom);
    end

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/scr1_dmem_router.md
Name: scr1_dmem_router

Overview:
- Sits directly downstream of the pipeline DMEM interface (pipe2dmem_*/dmem2pipe_*).
- Decodes each data request address and forwards the request to one of three targets: port1 = TCM, port2 = memory-mapped timer, port0 = external bus (default).
- Tracks the single outstanding transaction and returns that target's response and read data to the pipeline.
- Supports back-to-back issue: a new request may be accepted in the same cycle the previous response completes.

Parameters:
PORT1_ADDR_MASK, 32'hFFFF_0000, mask applied to addr for the port1 (TCM) match
PORT1_ADDR_PATTERN, 32'h0048_0000, port1 hit when (addr & MASK) == PATTERN
PORT2_ADDR_MASK, 32'hFFFF_FFE0, mask for the port2 (timer) match
PORT2_ADDR_PATTERN, 32'h0049_0000, port2 hit when (addr & MASK) == PATTERN

Ports:
clk  in  1  pipeline clock; single clock domain
rst  in  1  synchronous, active-high reset
dmem_req  in  1  pipeline request valid
dmem_cmd  in  type_scr1_mem_cmd_e  read/write command
dmem_width  in  type_scr1_mem_width_e  byte/hword/word
dmem_addr  in  `SCR1_DMEM_AWIDTH  request address
dmem_wdata  in  `SCR1_DMEM_DWIDTH  write data
dmem_req_ack  out  1  request accepted this cycle
dmem_rdata  out  `SCR1_DMEM_DWIDTH  read data, valid with dmem_resp==RDY_OK
dmem_resp  out  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER
portN_req  out  1  request to target N (N=0,1,2)
portN_cmd / portN_width / portN_addr / portN_wdata  out  as dmem_*  request fields driven straight from dmem_* (all ports)
portN_req_ack  in  1  target N accepted the request
portN_rdata  in  `SCR1_DMEM_DWIDTH  target N read data
portN_resp  in  type_scr1_mem_resp_e  target N response

Behaviour:
- Decode (combinational on dmem_addr): port1 on port1 match; else port2 on port2 match; else port0. Port1 has priority if both match.
- State machine, registered: fsm in {ADDR, DATA}, port_sel[1:0].
- Reset (rst sampled high at posedge): fsm=ADDR, port_sel=0.
- While rst is high, all portN_req=0, dmem_req_ack=0, dmem_resp=NOTRDY, dmem_rdata=0.
- ADDR state:
  - portX_req = dmem_req for the decoded port X only; the other ports' req = 0.
  - dmem_req_ack = portX_req_ack of the decoded port.
  - dmem_resp = NOTRDY; dmem_rdata = 0.
  - On dmem_req && ack: port_sel <= X, fsm <= DATA. Otherwise stay in ADDR.
- DATA state:
  - dmem_resp = port_sel's resp; dmem_rdata = port_sel's rdata when resp==RDY_OK, else 0.
  - Response of NOTRDY: all portN_req=0, ack=0, stay in DATA.
  - Response of RDY_ER: all portN_req=0, ack=0, fsm <= ADDR. No issue in the error cycle.
  - Response of RDY_OK: behave as ADDR for the new request (decode, forward req, return ack). On new req && ack: port_sel <= new X, stay in DATA. Otherwise fsm <= ADDR.
- Response latency: zero added. A response in cycle N reaches the pipeline in cycle N.
- Request latency: zero added. Request is accepted in the same cycle as the target ack.
- Outstanding limit: at most one transaction outstanding.
- Responses from non-selected ports are ignored in all states.
- A target response arriving while in ADDR is ignored.
- Reset mid-transaction: the transaction is abandoned; any later response from the old target is ignored, because the FSM is in ADDR.
- No combinational path from portN_resp to portN_req except through the DATA/RDY_OK issue path.

Test Plan:
- Reset: rst=1 for 2 cycles with dmem_req=1 -> all portN_req=0, dmem_resp=NOTRDY; after release, fsm in ADDR.
- TCM read: addr=32'h0048_0010, cmd=RD, port1_req_ack=1, next cycle port1_resp=RDY_OK, rdata=32'hDEAD_BEEF -> only port1_req high; dmem_req_ack=1; next cycle dmem_resp=RDY_OK, dmem_rdata=32'hDEAD_BEEF.
- Timer/external decode: addr=32'h0049_0008 -> port2_req; addr=32'h8000_0000 -> port0_req. Each read returns its own port's rdata; port0 holds ack low 3 cycles -> dmem_req_ack low 3 cycles and no state change.
- Back-to-back: port1 RDY_OK in the same cycle as a new req to 32'h8000_0004 with port0_req_ack=1 -> dmem_req_ack=1 that cycle; next response taken from port0, not port1.
- Error: port0_resp=RDY_ER with dmem_req=1 pending -> dmem_resp=RDY_ER, dmem_req_ack=0, all portN_req=0; request accepted on the next cycle.
- Reset mid-op: rst=1 while in DATA awaiting port2, port2_resp=RDY_OK one cycle after rst drops -> dmem_resp stays NOTRDY.
